// File: rtl/step_dda_generator.sv
// DDA step/dir generator: queued moves become step pulses via a phase accumulator.
// Optional halt input is compiled in with `define STEP_DDA_HALT_EN.
module step_dda_generator #(
    parameter int TICKDIV   = 64,
    parameter int ACCUMBITS = 64,
    parameter int STEPPULSE = 16,
    parameter int DIRSETUP  = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_steps,
    input  logic                 cmd_dir,
    input  logic [ACCUMBITS-1:0] cmd_rate,
    input  logic [ACCUMBITS-1:0] cmd_rate_delta,
    input  logic                 enable_in,
`ifdef STEP_DDA_HALT_EN
    input  logic                 halt,
`endif
    output logic                 step,
    output logic                 dir,
    output logic                 enable,
    output logic                 busy,
    output logic                 move_done,
    output logic                 step_overrun
);

    localparam int PSW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam int PLW = $clog2(STEPPULSE + 1);
    localparam int DSW = $clog2(DIRSETUP + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRSET = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [ACCUMBITS-1:0] accum_q, accum_d;
    logic [ACCUMBITS-1:0] rate_q, rate_d;
    logic [ACCUMBITS-1:0] delta_q, delta_d;
    logic [31:0]          steps_left_q, steps_left_d;
    logic [PSW-1:0]       presc_q, presc_d;
    logic [DSW-1:0]       dir_cnt_q, dir_cnt_d;
    logic [PLW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 enable_q, enable_d;
    logic                 overrun_q, overrun_d;

    logic [ACCUMBITS:0]   sum;
    logic [ACCUMBITS+1:0] rate_sum;
    logic [ACCUMBITS-1:0] rate_sat;
    logic                 tick;
    logic                 stop_req;

`ifdef STEP_DDA_HALT_EN
    assign stop_req  = !enable_in || halt;
    assign cmd_ready = (state_q == ST_IDLE) && !halt;
`else
    assign stop_req  = !enable_in;
    assign cmd_ready = (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d      = state_q;
        accum_d      = accum_q;
        rate_d       = rate_q;
        delta_d      = delta_q;
        steps_left_d = steps_left_q;
        presc_d      = presc_q;
        dir_cnt_d    = dir_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        step_d       = step_q;
        dir_d        = dir_q;
        enable_d     = enable_in;
        overrun_d    = overrun_q;

        sum      = {1'b0, accum_q} + {1'b0, rate_q};
        // Unsigned rate plus sign-extended delta; top bit flags a negative result.
        rate_sum = {2'b00, rate_q} + {{2{delta_q[ACCUMBITS-1]}}, delta_q};
        if (rate_sum[ACCUMBITS+1])  rate_sat = '0;
        else if (rate_sum[ACCUMBITS]) rate_sat = '1;
        else                          rate_sat = rate_sum[ACCUMBITS-1:0];
        tick = (presc_q == PSW'(TICKDIV - 1));

        if (step_q) begin
            if (pulse_cnt_q == '0) step_d = 1'b0;
            else                   pulse_cnt_d = pulse_cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    steps_left_d = cmd_steps;
                    rate_d       = cmd_rate;
                    delta_d      = cmd_rate_delta;
                    presc_d      = '0;
                    dir_cnt_d    = '0;
                    if (cmd_steps == '0 || stop_req) begin
                        state_d = ST_DONE;
                    end else if (cmd_dir != dir_q) begin
                        dir_d   = cmd_dir;
                        state_d = ST_DIRSET;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DIRSET: begin
                if (stop_req) begin
                    state_d = ST_DONE;
                end else if (dir_cnt_q == DSW'(DIRSETUP - 1)) begin
                    presc_d = '0;
                    state_d = ST_RUN;
                end else begin
                    dir_cnt_d = dir_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Abort zeroes the count so the stop stays latched while the pulse drains.
                if (steps_left_q == '0 || stop_req) begin
                    steps_left_d = '0;
                    if (!step_q) state_d = ST_DONE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        accum_d = sum[ACCUMBITS-1:0];
                        rate_d  = rate_sat;
                        if (sum[ACCUMBITS]) begin
                            steps_left_d = steps_left_q - 1'b1;
                            if (step_q) begin
                                overrun_d = 1'b1;
                            end else begin
                                step_d      = 1'b1;
                                pulse_cnt_d = PLW'(STEPPULSE - 1);
                            end
                        end
                    end
                end
            end
            default: begin
                accum_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            accum_q      <= '0;
            rate_q       <= '0;
            delta_q      <= '0;
            steps_left_q <= '0;
            presc_q      <= '0;
            dir_cnt_q    <= '0;
            pulse_cnt_q  <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            enable_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            accum_q      <= accum_d;
            rate_q       <= rate_d;
            delta_q      <= delta_d;
            steps_left_q <= steps_left_d;
            presc_q      <= presc_d;
            dir_cnt_q    <= dir_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            enable_q     <= enable_d;
            overrun_q    <= overrun_d;
        end
    end

    assign step         = step_q;
    assign dir          = dir_q;
    assign enable       = enable_q;
    assign busy         = (state_q != ST_IDLE);
    assign move_done    = (state_q == ST_DONE);
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_step_dda_generator.sv
// Bench for step_dda_generator: expected step rise cycles are queued when a move is
// issued and popped by a negedge monitor as pulses appear.
module tb_step_dda_generator;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, f_cmd_valid = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [63:0] cmd_rate = '0, cmd_rate_delta = '0;
    logic        enable_in = 1'b1;
    logic cmd_ready, step, dir, enable, busy, move_done, step_overrun;
    logic f_cmd_ready, f_step, f_dir, f_enable, f_busy, f_move_done, f_step_overrun;

    int tests_run = 0, tests_failed = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    step_dda_generator u_dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_rate(cmd_rate),
        .cmd_rate_delta(cmd_rate_delta), .enable_in(enable_in),
`ifdef STEP_DDA_HALT_EN
        .halt(1'b0),
`endif
        .step(step), .dir(dir), .enable(enable), .busy(busy),
        .move_done(move_done), .step_overrun(step_overrun));

    step_dda_generator #(.TICKDIV(2)) u_fast (
        .CLK(CLK), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_rate(cmd_rate),
        .cmd_rate_delta(cmd_rate_delta), .enable_in(enable_in),
`ifdef STEP_DDA_HALT_EN
        .halt(1'b0),
`endif
        .step(f_step), .dir(f_dir), .enable(f_enable), .busy(f_busy),
        .move_done(f_move_done), .step_overrun(f_step_overrun));

    // Scoreboard monitor for the default-parameter instance.
    int   exp_rise[$];
    bit   mon_en = 1'b1;
    logic step_prev = 1'b0;
    int   hi_cnt = 0, done_cnt = 0, last_done_cyc = -1;
    logic f_prev = 1'b0;
    int   f_rises = 0, f_done_cnt = 0;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (step && !step_prev) begin
                hi_cnt = 1;
                tests_run++;
                if (exp_rise.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rise_unexpected: step rose at cyc %0d, none expected", cyc);
                end else begin
                    if (cyc != exp_rise[0]) begin
                        tests_failed++;
                        $display("FAIL rise_time: step rose at cyc %0d, expected %0d", cyc, exp_rise[0]);
                    end
                    void'(exp_rise.pop_front());
                end
            end else if (step) begin
                hi_cnt++;
            end
            if (!step && step_prev) begin
                tests_run++;
                if (hi_cnt != 16) begin
                    tests_failed++;
                    $display("FAIL pulse_width: got %0d cycles, expected 16", hi_cnt);
                end
            end
        end
        if (move_done) begin done_cnt++; last_done_cyc = cyc; end
        step_prev = step;
        if (f_step && !f_prev) f_rises++;
        if (f_move_done) f_done_cnt++;
        f_prev = f_step;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference DDA: one iteration per tick, rise seen one cycle after the tick cycle.
    task automatic predict(input int run_start, input logic [63:0] rate, input logic [63:0] delta,
                           input int steps, input int max_ticks);
        logic [64:0] s;
        logic [65:0] rs;
        logic [63:0] acc, r;
        int left;
        acc = '0; r = rate; left = steps;
        for (int t = 0; t < max_ticks && left > 0; t++) begin
            s   = {1'b0, acc} + {1'b0, r};
            acc = s[63:0];
            rs  = {2'b00, r} + {{2{delta[63]}}, delta};
            if (rs[65])      r = '0;
            else if (rs[64]) r = '1;
            else             r = rs[63:0];
            if (s[64]) begin
                exp_rise.push_back(run_start + 64 * t + 64);
                left--;
            end
        end
    endtask

    task automatic send_cmd(input logic [31:0] st, input logic d, input logic [63:0] r,
                            input logic [63:0] dl, input bit fast, output int a);
        int n = 0;
        @(negedge CLK);
        while (!(fast ? f_cmd_ready : cmd_ready) && n < 50) begin @(negedge CLK); n++; end
        tests_run++;
        if (!(fast ? f_cmd_ready : cmd_ready)) begin
            tests_failed++;
            $display("FAIL ready_wait: cmd_ready=0 after %0d cycles, expected 1", n);
        end
        cmd_steps = st; cmd_dir = d; cmd_rate = r; cmd_rate_delta = dl;
        if (fast) f_cmd_valid = 1'b1; else cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0; f_cmd_valid = 1'b0;
        a = cyc;
        tests_run++;
        if ((fast ? f_cmd_ready : cmd_ready) !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_drop: cmd_ready=%b after accept, expected 0", fast ? f_cmd_ready : cmd_ready);
        end
    endtask

    task automatic wait_done(input int maxc, output int dc);
        int n0 = done_cnt;
        dc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK); #1;
            if (done_cnt != n0) begin dc = last_done_cyc; break; end
        end
        tests_run++;
        if (dc < 0) begin
            tests_failed++;
            $display("FAIL done_timeout: no move_done within %0d cycles", maxc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({step, dir, enable, busy, move_done, step_overrun, cmd_ready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected 0000001",
                     {step, dir, enable, busy, move_done, step_overrun, cmd_ready});
        end
        tests_run++;
        if ({f_step, f_dir, f_busy, f_step_overrun} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_fast: got %b, expected 0000", {f_step, f_dir, f_busy, f_step_overrun});
        end
        reset = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL enable_follow: enable=%b, expected 1", enable);
        end
    endtask

    task automatic test_const_velocity();
        int a, dc, n0;
        n0 = done_cnt;
        send_cmd(32'd4, 1'b0, 64'h4000_0000_0000_0000, 64'd0, 1'b0, a);
        predict(a, 64'h4000_0000_0000_0000, 64'd0, 4, 100);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_run: busy=%b, expected 1", busy);
        end
        wait_done(1500, dc);
        tests_run++;
        if (dc != a + 1041) begin
            tests_failed++;
            $display("FAIL cv_done_time: move_done at cyc %0d, expected %0d", dc, a + 1041);
        end
        repeat (2) @(negedge CLK);
        tests_run++;
        if (done_cnt != n0 + 1 || exp_rise.size() != 0) begin
            tests_failed++;
            $display("FAIL cv_counts: done pulses %0d, pending rises %0d, expected 1 and 0",
                     done_cnt - n0, exp_rise.size());
        end
    endtask

    task automatic test_dir_setup();
        int a, dc;
        send_cmd(32'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, a);
        tests_run++;
        if (dir !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_on_accept: dir=%b, expected 1", dir);
        end
        predict(a + 8, 64'h8000_0000_0000_0000, 64'd0, 1, 10);
        wait_done(400, dc);
        send_cmd(32'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, a);
        predict(a, 64'h8000_0000_0000_0000, 64'd0, 1, 10);
        wait_done(400, dc);
        tests_run++;
        if (exp_rise.size() != 0 || dir !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_moves: pending rises %0d dir=%b, expected 0 and 1", exp_rise.size(), dir);
        end
    endtask

    task automatic test_zero_steps();
        int a;
        send_cmd(32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, a);
        tests_run++;
        if (move_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_done: move_done=%b, expected 1", move_done);
        end
        @(negedge CLK);
        tests_run++;
        if (cmd_ready !== 1'b1 || move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_ready: ready=%b done=%b, expected 1 0", cmd_ready, move_done);
        end
    endtask

    task automatic test_enable_idle();
        int a;
        enable_in = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_low: enable=%b, expected 0", enable);
        end
        send_cmd(32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, a);
        tests_run++;
        if (move_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL disabled_done: move_done=%b, expected 1", move_done);
        end
        enable_in = 1'b1;
        repeat (300) @(negedge CLK);
    endtask

    task automatic test_accel();
        int a, dc;
        send_cmd(32'd8, 1'b1, 64'd0, 64'h1000_0000_0000_0000, 1'b0, a);
        predict(a, 64'd0, 64'h1000_0000_0000_0000, 8, 100);
        wait_done(2000, dc);
        tests_run++;
        if (exp_rise.size() != 0) begin
            tests_failed++;
            $display("FAIL accel_rises: %0d expected rises missing, expected 0", exp_rise.size());
        end
    endtask

    task automatic test_saturate();
        int a, dc;
        send_cmd(32'd4, 1'b1, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, a);
        predict(a, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 4, 20);
        repeat (1200) @(negedge CLK);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_stall: busy=%b, expected 1", busy);
        end
        enable_in = 1'b0;
        wait_done(5, dc);
        enable_in = 1'b1;
    endtask

    task automatic test_abort();
        int a, dc;
        send_cmd(32'd4, 1'b1, 64'h4000_0000_0000_0000, 64'd0, 1'b0, a);
        exp_rise.push_back(a + 256);
        while (cyc < a + 261) @(negedge CLK);
        enable_in = 1'b0;
        tests_run++;
        if (enable !== 1'b1 || step !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre: enable=%b step=%b, expected 1 1", enable, step);
        end
        wait_done(40, dc);
        tests_run++;
        if (dc != a + 273) begin
            tests_failed++;
            $display("FAIL abort_done: move_done at cyc %0d, expected %0d", dc, a + 273);
        end
        repeat (600) @(negedge CLK);
        enable_in = 1'b1;
    endtask

    task automatic test_overrun();
        int a, n0;
        n0 = f_done_cnt;
        tests_run++;
        if (f_step_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_pre: step_overrun=%b, expected 0", f_step_overrun);
        end
        send_cmd(32'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, a);
        for (int i = 0; i < 100 && f_done_cnt == n0; i++) begin @(negedge CLK); #1; end
        repeat (40) @(negedge CLK);
        tests_run++;
        if (f_done_cnt != n0 + 1) begin
            tests_failed++;
            $display("FAIL ovr_done: %0d done pulses, expected 1", f_done_cnt - n0);
        end
        tests_run++;
        if (f_step_overrun !== 1'b1 || f_rises != 1) begin
            tests_failed++;
            $display("FAIL ovr_result: overrun=%b pulses=%0d, expected 1 and 1", f_step_overrun, f_rises);
        end
        tests_run++;
        if (step_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_main: step_overrun=%b, expected 0", step_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        send_cmd(32'd4, 1'b1, 64'h4000_0000_0000_0000, 64'd0, 1'b0, a);
        exp_rise.push_back(a + 256);
        while (cyc < a + 260) @(negedge CLK);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({step, dir, enable, busy, move_done, step_overrun} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got %b, expected 000000",
                     {step, dir, enable, busy, move_done, step_overrun});
        end
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (cmd_ready !== 1'b1 || exp_rise.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_recover: ready=%b pending=%0d, expected 1 and 0", cmd_ready, exp_rise.size());
        end
    endtask

    initial begin
        test_reset();
        test_const_velocity();
        test_dir_setup();
        test_zero_steps();
        test_enable_idle();
        test_accel();
        test_saturate();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
